// File: rtl/scan_data_selector.sv
// Channel selector with manual selection and timed round-robin scanning.
// Selected data, active channel index and change pulse are all registered.
module scan_data_selector #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 16,
    localparam int CHW     = $clog2(CHANNELS),
    localparam int CNTW    = $clog2(DWELL) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHW-1:0]            sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          q,
    output logic [CHW-1:0]            ch,
    output logic                      ch_chg
);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    localparam logic [CHW:0]    CH_LIMIT = (CHW+1)'(CHANNELS);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(CHANNELS - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [CHW-1:0]    r_ch;
    logic [CHW-1:0]    w_ch_nx;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_cur;
    logic [CNTW-1:0]   w_cnt_nx;
    logic [WIDTH-1:0]  r_q;
    logic              r_ch_chg;

    // Next-state, next-channel and dwell-counter decode from the current mode input
    always_comb begin
        w_state_nx = mode ? ST_SCAN : ST_MANUAL;
        w_ch_nx    = r_ch;
        w_cnt_nx   = {CNTW{1'b0}};
        // A fresh SCAN entry always starts its dwell from zero.
        w_cnt_cur  = (r_state == ST_SCAN) ? r_cnt : {CNTW{1'b0}};
        case (w_state_nx)
            ST_MANUAL: begin
                if ({1'b0, sel} < CH_LIMIT) begin
                    w_ch_nx = sel;
                end else begin
                    w_ch_nx = r_ch;
                end
                w_cnt_nx = {CNTW{1'b0}};
            end
            ST_SCAN: begin
                if (hold) begin
                    w_cnt_nx = w_cnt_cur;
                end else if (w_cnt_cur == CNT_LAST) begin
                    w_cnt_nx = {CNTW{1'b0}};
                    w_ch_nx  = (r_ch == CH_LAST) ? {CHW{1'b0}} : r_ch + 1'b1;
                end else begin
                    w_cnt_nx = w_cnt_cur + 1'b1;
                end
            end
            default: begin
                w_ch_nx  = r_ch;
                w_cnt_nx = {CNTW{1'b0}};
            end
        endcase
    end

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Channel, dwell counter, selected data and change pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= {CHW{1'b0}};
            r_cnt    <= {CNTW{1'b0}};
            r_q      <= {WIDTH{1'b0}};
            r_ch_chg <= 1'b0;
        end else begin
            r_ch     <= w_ch_nx;
            r_cnt    <= w_cnt_nx;
            r_q      <= din[int'(w_ch_nx)*WIDTH +: WIDTH];
            r_ch_chg <= (w_ch_nx != r_ch);
        end
    end

    assign q      = r_q;
    assign ch     = r_ch;
    assign ch_chg = r_ch_chg;

endmodule

// File: doc/scan_data_selector.md
SCAN_DATA_SELECTOR -- requirements
Module: scan_data_selector

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each data channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (>=2); CHW = clog2(CHANNELS).
REQ-003 Parameter DWELL, default 16, cycles spent on each channel in scan mode (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  CHANNELS*WIDTH  packed channel data; channel i occupies din[i*WIDTH +: WIDTH].
REQ-007 sel  input  CHW  manual-mode channel request.
REQ-008 mode  input  1  0 = MANUAL, 1 = SCAN.
REQ-009 hold  input  1  SCAN only: freezes dwell counter and channel index.
REQ-010 q  output  WIDTH  registered selected data.
REQ-011 ch  output  CHW  registered index of the active channel.
REQ-012 ch_chg  output  1  one-cycle pulse: ch changed on the previous edge.

Function
REQ-013 The block SHALL hold two states, MANUAL and SCAN; the state register SHALL equal mode sampled on the previous edge.
REQ-014 Next channel (ch_nx) SHALL be computed each cycle; ch <= ch_nx, q <= din slice ch_nx, on every edge (one-cycle latency, no bubbles).
REQ-015 MANUAL: ch_nx = sel if sel < CHANNELS, else ch_nx = ch (out-of-range request ignored, no error).
REQ-016 SCAN, hold=0: dwell counter cnt increments; when cnt == DWELL-1, cnt <= 0 and ch_nx = (ch == CHANNELS-1) ? 0 : ch+1; otherwise ch_nx = ch.
REQ-017 SCAN, hold=1: cnt and ch frozen; q SHALL still track din[ch] every cycle.
REQ-018 DWELL = 1: channel SHALL advance every non-held cycle.
REQ-019 Entry to SCAN (mode 0->1): cnt SHALL be 0 on the first SCAN cycle; scan SHALL start from the current ch, not channel 0.
REQ-020 Exit to SCAN->MANUAL (mode 1->0): the MANUAL rule of REQ-015 applies on the first cycle mode=0; cnt SHALL be cleared.
REQ-021 In MANUAL, cnt SHALL remain 0; hold SHALL be ignored.
REQ-022 ch_chg SHALL be 1 exactly in the cycle after an edge where ch_nx != ch, else 0; no pulse when sel re-requests the current channel.
REQ-023 cnt width SHALL be clog2(DWELL)+1 bits minimum; no overflow for any legal DWELL.
REQ-024 Non-power-of-two CHANNELS SHALL wrap at CHANNELS-1 and never present an index >= CHANNELS on ch.

Reset
REQ-025 rst_n low SHALL immediately force q = 0, ch = 0, ch_chg = 0, cnt = 0, state = MANUAL, independent of clk.
REQ-026 Reset asserted mid-scan SHALL discard dwell progress; after release, operation SHALL resume per mode on the first rising edge with rst_n high.

Verification
REQ-027 WIDTH=8, CHANNELS=4; din = {8'h44,8'h33,8'h22,8'h11}, MANUAL, sel=2 -> q = 8'h33, ch = 2 one edge later, ch_chg pulses once.
REQ-028 MANUAL, CHANNELS=3, sel=3 (out of range) while ch=1 -> ch stays 1, q = din[1], ch_chg stays 0.
REQ-029 SCAN, DWELL=4, hold=0 from ch=0 -> ch sequence 0,1,2,3,0 at 4-cycle intervals, one ch_chg pulse per change, q matches din[ch] each cycle.
REQ-030 SCAN, DWELL=4, hold=1 for 10 cycles at cnt=2 -> ch unchanged, q follows changing din[ch]; after hold=0, advance occurs 2 cycles later.
REQ-031 SCAN at ch=2, cnt=3, drive rst_n low between edges -> q, ch, ch_chg = 0 immediately; after release with mode=1, first advance after DWELL cycles.
REQ-032 MANUAL ch=1 -> mode=1 with DWELL=1 -> ch 2,3,0 on successive edges; mode=0, sel=1 -> ch=1 next edge.
